multicycle_control: RTL and testbench

Main controller for the multicycle RV32I datapath. It decodes the fetched instruction fields and sequences the datapath through fetch, decode, execute, memory and writeback states. It drives the select, enable and aluControl inputs of the shared ALU and consumes the ALU's zero flag for branch resolution. It sits between the instruction register and the datapath (PC, memory interface, register file, ALU).

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional macro BNE_EN: BEQ state honours funct3==001 as bne (branch on !zero).
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       regWrite,
  output logic [1:0] immSrc,
  output logic [2:0] aluControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t     r_state;
  state_t     w_state;
  state_t     w_next;
  logic [1:0] w_aluOp;
  logic       w_pcUpdate;
  logic       w_branch;
  logic       w_brCond;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Outputs decode from FETCH while reset is high, so an interrupted
  // MEMWRITE/ALUWB never issues its write during the reset cycle.
  always_comb begin
    w_state = reset ? S_FETCH : r_state;
  end

  always_comb begin
    w_next = S_FETCH;
    case (w_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECUTER;
          7'b0010011:             w_next = S_EXECUTEI;
          7'b1101111:             w_next = S_JAL;
          7'b1100011:             w_next = S_BEQ;
          default:                w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    regWrite   = 1'b0;
    w_aluOp    = 2'b00;
    w_pcUpdate = 1'b0;
    w_branch   = 1'b0;
    case (w_state)
      S_FETCH: begin
        irWrite    = 1'b1;
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
        w_pcUpdate = 1'b1;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECUTER: begin
        aluSrcA = 2'b10;
        w_aluOp = 2'b10;
      end
      S_EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        w_aluOp = 2'b10;
      end
      S_ALUWB:    regWrite = 1'b1;
      S_BEQ: begin
        aluSrcA  = 2'b10;
        w_aluOp  = 2'b01;
        w_branch = 1'b1;
      end
      S_JAL: begin
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        w_pcUpdate = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef BNE_EN
    w_brCond = (funct3 == 3'b001) ? ~zero : zero;
`else
    w_brCond = zero;
`endif
    pcWrite = w_pcUpdate | (w_branch & w_brCond);
  end

  always_comb begin
    case (op)
      7'b0100011: immSrc = 2'b01;
      7'b1100011: immSrc = 2'b10;
      7'b1101111: immSrc = 2'b11;
      default:    immSrc = 2'b00;
    endcase
  end

  // Only register-form sub sets op[5]; addi with imm[10]=1 stays add.
  always_comb begin
    aluControl = 3'b000;
    case (w_aluOp)
      2'b01: aluControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  aluControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
      default: aluControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected output vectors queued per instruction.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;
  logic [15:0] w_obs;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8,
                 S_BEQ = 9, S_JAL = 10;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011,
                         OP_ILL = 7'b1111111;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
    .immSrc(immSrc), .aluControl(aluControl)
  );

  assign w_obs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                  regWrite, immSrc, aluControl};

  always #5 clk = ~clk;

  // Reference outputs for a named state, built from the state output table.
  function automatic logic [15:0] model(int st, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic pcu, br, adr, mw, irw, rw, cond, pcw;
    logic [1:0] res, sa, sbs, aop, imm;
    logic [2:0] ac;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 2'b00; sa = 2'b00; sbs = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:    begin irw = 1; sbs = 2'b10; res = 2'b10; pcu = 1; end
      S_DECODE:   begin sa = 2'b01; sbs = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sbs = 2'b01; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin res = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECUTER: begin sa = 2'b10; aop = 2'b10; end
      S_EXECUTEI: begin sa = 2'b10; sbs = 2'b01; aop = 2'b10; end
      S_ALUWB:    rw = 1;
      S_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; end
      S_JAL:      begin sa = 2'b01; sbs = 2'b10; pcu = 1; end
      default: ;
    endcase
    if (o == OP_SW) imm = 2'b01;
    else if (o == OP_BEQ) imm = 2'b10;
    else if (o == OP_JAL) imm = 2'b11;
    else imm = 2'b00;
    ac = 3'b000;
    if (aop == 2'b01) ac = 3'b001;
    else if (aop == 2'b10) begin
      if (f3 == 3'b000) ac = (f7 && o == OP_R) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) ac = 3'b101;
      else if (f3 == 3'b110) ac = 3'b011;
      else if (f3 == 3'b111) ac = 3'b010;
    end
`ifdef BNE_EN
    cond = (f3 == 3'b001) ? ~z : z;
`else
    cond = z;
`endif
    pcw = pcu | (br & cond);
    return {pcw, adr, mw, irw, res, sa, sbs, rw, imm, ac};
  endfunction

  // Drives one instruction for n cycles, queueing the expected state sequence s0..s4.
  task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int n, input int s0, input int s1,
                             input int s2, input int s3, input int s4);
    int st[5];
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3; st[4] = s4;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int i = 0; i < n; i++) exp_q.push_back(model(st[i], o, f3, f7, z));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back(w_obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic lw_seq(input logic [2:0] f3);
    drive_instr(OP_LW, f3, 1'b0, 1'b0, 5, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB);
  endtask

  task automatic test_reset();
    logic [15:0] e, a;
    reset = 1'b1; op = OP_I; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model(S_FETCH, OP_I, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    obs_q.push_back(w_obs);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_instr(OP_I, 3'b000, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_lw();
    logic [15:0] e, a;
    lw_seq(3'b010);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL lw cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_alu_decode();
    logic [15:0] e, a;
    drive_instr(OP_R, 3'b000, 1'b1, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
    drive_instr(OP_I, 3'b000, 1'b1, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH);
    drive_instr(OP_R, 3'b000, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
    drive_instr(OP_R, 3'b010, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
    drive_instr(OP_R, 3'b110, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
    drive_instr(OP_I, 3'b111, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH);
    drive_instr(OP_R, 3'b100, 1'b1, 1'b0, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL alu_decode cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] e, a;
    drive_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
    drive_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
    drive_instr(OP_BEQ, 3'b001, 1'b0, 1'b0, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
    drive_instr(OP_BEQ, 3'b001, 1'b0, 1'b1, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL branch cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_jal_illegal();
    logic [15:0] e, a;
    drive_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH);
    drive_instr(OP_ILL, 3'b111, 1'b1, 1'b1, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH);
    drive_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL jal_illegal cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_sw_reset_mid();
    logic [15:0] e, a;
    drive_instr(OP_SW, 3'b010, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH);
    drive_instr(OP_SW, 3'b010, 1'b0, 1'b0, 3, S_FETCH, S_DECODE, S_MEMADR, S_FETCH, S_FETCH);
    reset = 1'b1;
    exp_q.push_back(model(S_FETCH, OP_SW, 3'b010, 1'b0, 1'b0));
    @(negedge clk);
    obs_q.push_back(w_obs);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_instr(OP_SW, 3'b010, 1'b0, 1'b0, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL sw_reset_mid cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, a;
    logic [2:0] f3;
    logic f7, z;
    for (int k = 0; k < 40; k++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: lw_seq(f3);
        1: drive_instr(OP_SW, f3, f7, z, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH);
        2: drive_instr(OP_R, f3, f7, z, 4, S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH);
        3: drive_instr(OP_I, f3, f7, z, 4, S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH);
        4: drive_instr(OP_BEQ, {2'b00, f3[0]}, f7, z, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
        5: drive_instr(OP_JAL, f3, f7, z, 4, S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH);
        default: drive_instr(7'b1010111, f3, f7, z, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH);
      endcase
    end
    drive_instr(OP_ILL, 3'b000, 1'b0, 1'b0, 1, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", i, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu_decode();
    test_branch();
    test_jal_illegal();
    test_sw_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion within 200000");
    $fatal(1, "timeout");
  end

endmodule
